demux32bit_1x4_capture: RTL and testbench

//   Registered 1-to-NOUT demultiplexer with handshake: the write-side dual of the datapath muxes.

---
 rtl/demux32bit_1x4_capture.sv | 84 ++++++++
 tb/tb_demux32bit_1x4_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux32bit_1x4_capture.sv
// Registered 1-to-NOUT demultiplexer with per-slot valid/ack handshake.
// A word offered on in_data is steered into the holding register of slot
// sel and held there, flagged valid, until the consumer acks it. A word
// addressed to a slot that does not exist (sel >= NOUT) is always accepted
// and discarded, and reported by a one-cycle drop pulse.
module demux32bit_1x4_capture #(
  parameter int WIDTH = 32,
  parameter int NOUT  = 4,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ack,
  output logic                  drop,
  output logic [CNTW-1:0]       xfer_cnt
);

  logic [NOUT-1:0] sel_dec;
  logic [NOUT-1:0] wr_en;
  logic [NOUT-1:0] clr_en;
  logic            sel_legal;
  logic            fire;

  // Decode sel to a one-hot slot select; all-zero means the slot does not exist.
  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NOUT; i++) begin
      sel_dec[i] = (sel == 2'(i));
    end
  end

  // Ready depends only on the addressed slot: empty, or being drained this cycle.
  // An ack on the addressed slot frees it on the same edge, so streaming
  // into a slot that is acked every cycle never bubbles.
  always_comb begin
    sel_legal = |sel_dec;
    in_ready  = sel_legal ? |(sel_dec & (~out_valid | out_ack)) : 1'b1;
    fire      = in_valid && in_ready;
    wr_en     = fire ? sel_dec : '0;
    clr_en    = out_ack & out_valid & ~wr_en;
  end

  // Capture the incoming word into the written slot; acked slots keep their data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        if (wr_en[i]) begin
          out_data[i*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

  // Valid flags: set on write, cleared by ack only when no write lands in the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= '0;
    end else begin
      out_valid <= (out_valid & ~clr_en) | wr_en;
    end
  end

  // Count words delivered to real slots (free-running wrap); flag sunk words for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt <= '0;
      drop     <= 1'b0;
    end else begin
      drop <= fire && !sel_legal;
      if (fire && sel_legal) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux32bit_1x4_capture.sv
// Bench for demux32bit_1x4_capture: a 4-slot instance checked through an
// expected-word queue drained by a monitor on every observed transfer,
// plus a 3-slot instance for the sunk-word (drop) path.
module tb_demux32bit_1x4_capture;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   sel;
  logic [31:0]  in_data;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ack;
  logic         drop;
  logic [15:0]  xfer_cnt;

  logic         in_valid3;
  logic         in_ready3;
  logic [95:0]  out_data3;
  logic [2:0]   out_valid3;
  logic [2:0]   out_ack3;
  logic         drop3;
  logic [15:0]  xfer_cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  slot;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic       pend = 1'b0;
  logic [1:0] pend_sel = 2'd0;

  demux32bit_1x4_capture #(.WIDTH(32), .NOUT(4), .CNTW(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .out_ack(out_ack), .drop(drop), .xfer_cnt(xfer_cnt)
  );

  demux32bit_1x4_capture #(.WIDTH(32), .NOUT(3), .CNTW(16)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel), .in_data(in_data), .out_data(out_data3), .out_valid(out_valid3),
    .out_ack(out_ack3), .drop(drop3), .xfer_cnt(xfer_cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] slot, input logic [31:0] data);
    exp_t e;
    e.slot = slot;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: a transfer seen before an edge must show up in its slot after that edge.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_fire", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_slot", 64'(pend_sel), 64'(e.slot));
        check("sb_valid", 64'(out_valid[e.slot]), 64'd1);
        check("sb_data", 64'(out_data[int'(e.slot)*32 +: 32]), 64'(e.data));
      end
    end
    pend     = reset_n && in_valid && in_ready;
    pend_sel = sel;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  localparam logic [3:0] STREAM_VALID [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    sel       = 2'd0;
    in_data   = 32'd0;
    out_ack   = 4'd0;
    out_ack3  = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_data", 64'(out_data != 128'd0), 64'h0);
    check("rst_cnt", 64'(xfer_cnt), 64'h0);
    check("rst_drop", 64'(drop), 64'h0);
    reset_n = 1'b1;
    tick();

    // Load slot 2, then drop reset mid-cycle
    sel = 2'd2; in_data = 32'hCAFE0002; in_valid = 1'b1;
    push(2'd2, 32'hCAFE0002);
    tick();
    in_valid = 1'b0;
    check("t1_loaded", 64'(out_valid), 64'h4);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_async_valid", 64'(out_valid), 64'h0);
    check("t1_async_data", 64'(out_data != 128'd0), 64'h0);
    check("t1_async_cnt", 64'(xfer_cnt), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single word to slot 1, then ack it
    sel = 2'd1; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    push(2'd1, 32'hDEADBEEF);
    tick();
    in_valid = 1'b0;
    check("t2_valid", 64'(out_valid), 64'h2);
    check("t2_data", 64'(out_data[63:32]), 64'hDEADBEEF);
    check("t2_cnt", 64'(xfer_cnt), 64'h1);
    out_ack = 4'b0010;
    tick();
    out_ack = 4'b0000;
    check("t2_ack_valid", 64'(out_valid), 64'h0);
    check("t2_ack_data", 64'(out_data[63:32]), 64'hDEADBEEF);

    // Full slot 0 stalls for 5 cycles, then ack and replace on the same edge
    sel = 2'd0; in_data = 32'hA5A5A5A5; in_valid = 1'b1;
    push(2'd0, 32'hA5A5A5A5);
    tick();
    in_data = 32'h12345678;
    out_ack = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_stall_ready", 64'(in_ready), 64'h0);
      check("t3_stall_data", 64'(out_data[31:0]), 64'hA5A5A5A5);
      @(posedge clk);
      #1;
    end
    out_ack = 4'b0000;
    check("t3_stall_cnt", 64'(xfer_cnt), 64'h2);
    push(2'd0, 32'h12345678);
    out_ack = 4'b0001;
    @(negedge clk);
    check("t3_ack_ready", 64'(in_ready), 64'h1);
    tick();
    out_ack = 4'b0000;
    in_valid = 1'b0;
    check("t3_replace_valid", 64'(out_valid), 64'h1);
    check("t3_replace_data", 64'(out_data[31:0]), 64'h12345678);
    check("t3_cnt", 64'(xfer_cnt), 64'h3);
    out_ack = 4'b0001;
    tick();
    out_ack = 4'b0000;
    check("t3_drained", 64'(out_valid), 64'h0);

    // 3-slot instance: sel=3 is sunk with a drop pulse; sel=2 is a real slot
    sel = 2'd3; in_data = 32'h0BAD0BAD; in_valid3 = 1'b1;
    @(negedge clk);
    check("t4_ready", 64'(in_ready3), 64'h1);
    tick();
    in_valid3 = 1'b0;
    check("t4_drop", 64'(drop3), 64'h1);
    check("t4_valid", 64'(out_valid3), 64'h0);
    check("t4_cnt", 64'(xfer_cnt3), 64'h0);
    tick();
    check("t4_drop_clear", 64'(drop3), 64'h0);
    sel = 2'd2; in_data = 32'h00000033; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    check("t4_legal_valid", 64'(out_valid3), 64'h4);
    check("t4_legal_drop", 64'(drop3), 64'h0);
    check("t4_legal_cnt", 64'(xfer_cnt3), 64'h1);

    // Streaming into all four slots with every slot acked every cycle
    out_ack = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); in_data = 32'(k + 1); in_valid = 1'b1;
      push(2'(k), 32'(k + 1));
      @(negedge clk);
      check("t5_ready", 64'(in_ready), 64'h1);
      tick();
      check("t5_onehot", 64'(out_valid), 64'(STREAM_VALID[k]));
    end
    in_valid = 1'b0;
    tick();
    out_ack = 4'b0000;
    check("t5_empty", 64'(out_valid), 64'h0);
    check("t5_cnt", 64'(xfer_cnt), 64'h7);

    // Counter wrap: 65535 transfers reach FFFF, one more wraps to 0
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    sel = 2'd0; out_ack = 4'b0001; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 32'(i);
      push(2'd0, 32'(i));
      tick();
    end
    in_valid = 1'b0;
    check("t6_cnt_max", 64'(xfer_cnt), 64'hFFFF);
    in_data = 32'h00C0FFEE; in_valid = 1'b1;
    push(2'd0, 32'h00C0FFEE);
    tick();
    in_valid = 1'b0;
    check("t6_cnt_wrap", 64'(xfer_cnt), 64'h0);
    check("t6_drop", 64'(drop), 64'h0);
    out_ack = 4'b0000;

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
